ov7670_config_seq: RTL and testbench

- Sequences the OV7670 default-settings ROM into the SCCB write master after power-up, or on a re-configure request.
- Walks ROM addresses from 0 and decodes each 16-bit word {reg_addr, reg_value}.
- Issues one SCCB register write per entry, executes delay entries and stops at the end marker.
- Sits between the top-level camera bring-up logic and the SCCB master; the ROM is combinational and addressed directly by this block.

---
 rtl/ov7670_config_seq.sv | 120 ++++++++++++
 tb/tb_ov7670_config_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 settings ROM from address 0 and turns each entry into an SCCB
// register write, a millisecond-scale delay, or the end of the sequence.
module ov7670_config_seq #(
  parameter int unsigned DELAY_UNIT_CYCLES = 27000,
  parameter int unsigned MAX_RETRY         = 3,
  parameter int unsigned ROM_LAST_ADDR     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        sccb_valid_o,
  input  logic        sccb_ready_i,
  output logic [7:0]  sccb_reg_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_done_i,
  input  logic        sccb_nack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  fail_addr_o
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, REQ, WAIT, DELAY, NEXT, DONE, ERROR
  } state_t;

  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
  localparam logic [7:0] LAST_ADDR   = 8'(ROM_LAST_ADDR);

  state_t      state;
  logic [7:0]  retry_cnt;
  logic [31:0] delay_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rom_addr_o   <= '0;
      sccb_valid_o <= 1'b0;
      sccb_reg_o   <= '0;
      sccb_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      fail_addr_o  <= '0;
      retry_cnt    <= '0;
      delay_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            rom_addr_o <= '0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            retry_cnt  <= '0;
            busy_o     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_data_i == 16'hFFFF) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else if (rom_data_i[15:8] == 8'hFF) begin
            delay_cnt <= 32'(rom_data_i[7:0]) * 32'(DELAY_UNIT_CYCLES);
            state     <= DELAY;
          end else begin
            sccb_reg_o   <= rom_data_i[15:8];
            sccb_data_o  <= rom_data_i[7:0];
            sccb_valid_o <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (sccb_ready_i) begin
            sccb_valid_o <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (sccb_done_i) begin
            if (!sccb_nack_i) begin
              state <= NEXT;
            end else if (retry_cnt < RETRY_LIMIT) begin
              // reg/data registers still hold the failed write, so a retry only re-raises valid
              retry_cnt    <= retry_cnt + 8'd1;
              sccb_valid_o <= 1'b1;
              state        <= REQ;
            end else begin
              fail_addr_o <= rom_addr_o;
              busy_o      <= 1'b0;
              error_o     <= 1'b1;
              state       <= ERROR;
            end
          end
        end
        DELAY: begin
          if (delay_cnt == '0) state <= NEXT;
          else                 delay_cnt <= delay_cnt - 32'd1;
        end
        NEXT: begin
          retry_cnt <= '0;
          if (rom_addr_o == LAST_ADDR) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            rom_addr_o <= rom_addr_o + 8'd1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM and SCCB responder models, a transaction-level
// reference that predicts write order, final status and start-to-finish latency.
module tb_ov7670_config_seq;

  localparam int UNIT      = 4;
  localparam int MAX_R     = 3;
  localparam int DONE_LAT  = 10;
  localparam int BOUND     = 20000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        sccb_valid_o;
  logic        sccb_ready_i;
  logic [7:0]  sccb_reg_o;
  logic [7:0]  sccb_data_o;
  logic        sccb_done_i;
  logic        sccb_nack_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  fail_addr_o;

  logic [15:0] rom [256];
  int          nack_plan [256];
  int          nack_left [256];
  int          stall_cfg, stall_left, cnt_down, writes_seen;
  int          cyc = 0;
  int          n_total = 0, n_pass = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data_i = rom[rom_addr_o];

  ov7670_config_seq #(
    .DELAY_UNIT_CYCLES(UNIT),
    .MAX_RETRY(MAX_R),
    .ROM_LAST_ADDR(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .sccb_valid_o(sccb_valid_o), .sccb_ready_i(sccb_ready_i),
    .sccb_reg_o(sccb_reg_o), .sccb_data_o(sccb_data_o),
    .sccb_done_i(sccb_done_i), .sccb_nack_i(sccb_nack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .fail_addr_o(fail_addr_o)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk the ROM by the sequencing rules, queue expected writes, sum cycle costs
  task automatic build_model(output int lat, output bit m_done, output bit m_err,
                             output logic [7:0] m_fail, output logic [7:0] m_last);
    logic [15:0] w;
    int n, k, req_cost;
    exp_q.delete();
    lat = 0; m_done = 0; m_err = 0; m_fail = '0; m_last = '0;
    req_cost = stall_cfg + 1 + DONE_LAT;
    for (int a = 0; a < 256; a++) begin
      w = rom[a];
      if (w == 16'hFFFF) begin
        lat += 2; m_done = 1; m_last = 8'(a); break;
      end else if (w[15:8] == 8'hFF) begin
        lat += int'(w[7:0]) * UNIT + 4;
      end else begin
        n = nack_plan[a];
        k = (n > MAX_R) ? MAX_R + 1 : n + 1;
        for (int r = 0; r < k; r++) exp_q.push_back(w);
        if (n > MAX_R) begin
          lat += 2 + k * req_cost; m_err = 1; m_fail = 8'(a); m_last = 8'(a); break;
        end
        lat += 3 + k * req_cost;
      end
      if (a == 255) begin
        m_done = 1; m_last = 8'd255;
      end
    end
  endtask

  // SCCB responder plus the single per-cycle compare process
  initial begin : monitor
    bit prev_valid, prev_acc, acc;
    logic [15:0] prev_wd, got;
    prev_valid = 0; prev_acc = 0; prev_wd = '0;
    sccb_ready_i = 1'b1; sccb_done_i = 1'b0; sccb_nack_i = 1'b0;
    cnt_down = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cnt_down = 0; sccb_done_i = 1'b0; sccb_nack_i = 1'b0; prev_valid = 0;
        continue;
      end
      chk(!(done_o && error_o), "done_error_exclusive", {done_o, error_o}, 0);
      if (prev_valid && !prev_acc) begin
        chk(sccb_valid_o, "valid_held", sccb_valid_o, 1);
        chk({sccb_reg_o, sccb_data_o} == prev_wd, "req_stable", {sccb_reg_o, sccb_data_o}, prev_wd);
      end
      sccb_done_i = 1'b0; sccb_nack_i = 1'b0;
      if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0) begin
          sccb_done_i = 1'b1;
          if (nack_left[rom_addr_o] > 0) begin
            sccb_nack_i = 1'b1;
            nack_left[rom_addr_o]--;
          end
        end
      end
      if (sccb_valid_o && stall_left > 0) begin
        sccb_ready_i = 1'b0; stall_left--;
      end else begin
        sccb_ready_i = 1'b1;
      end
      acc = sccb_valid_o && sccb_ready_i;
      if (acc) begin
        cnt_down = DONE_LAT; stall_left = stall_cfg; writes_seen++;
        got = {sccb_reg_o, sccb_data_o};
        if (exp_q.size() == 0) chk(0, "unexpected_write", got, 0);
        else begin
          prev_wd = exp_q.pop_front();
          chk(got == prev_wd, "write_order", got, prev_wd);
        end
      end
      prev_valid = sccb_valid_o; prev_acc = acc; prev_wd = {sccb_reg_o, sccb_data_o};
    end
  end

  task automatic check_reset_vals(input string tag);
    chk(rom_addr_o == 0,   {tag, "_rom_addr"},   rom_addr_o, 0);
    chk(!sccb_valid_o,     {tag, "_valid"},      sccb_valid_o, 0);
    chk(sccb_reg_o == 0,   {tag, "_reg"},        sccb_reg_o, 0);
    chk(sccb_data_o == 0,  {tag, "_data"},       sccb_data_o, 0);
    chk(!busy_o,           {tag, "_busy"},       busy_o, 0);
    chk(!done_o,           {tag, "_done"},       done_o, 0);
    chk(!error_o,          {tag, "_error"},      error_o, 0);
    chk(fail_addr_o == 0,  {tag, "_fail_addr"},  fail_addr_o, 0);
  endtask

  task automatic run_seq(input int inj, input int lat_lit, input int wr_lit, input int gap_lit);
    int s, lat, m_lat, t1, t2, k;
    bit m_done, m_err, injected;
    logic [7:0] m_fail, m_last, a;
    build_model(m_lat, m_done, m_err, m_fail, m_last);
    nack_left = nack_plan; stall_left = stall_cfg; writes_seen = 0;
    t1 = -1; t2 = -1; injected = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; s = cyc;
    chk(rom_addr_o == 0 && busy_o && !done_o && !error_o, "start_state",
        {rom_addr_o, busy_o, done_o, error_o}, 32'h4);
    k = 0;
    while (!(done_o || error_o) && k < BOUND) begin
      if (rom_addr_o == 8'd1 && t1 < 0) t1 = cyc;
      if (rom_addr_o == 8'd2 && t2 < 0) t2 = cyc;
      if (inj >= 0 && !injected && rom_addr_o == 8'(inj) && cnt_down >= 3) begin
        injected = 1; a = rom_addr_o; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; k++;
        chk(rom_addr_o == a && busy_o, "start_ignored_busy", rom_addr_o, a);
        continue;
      end
      @(negedge clk); k++;
    end
    if (k >= BOUND) chk(0, "timeout", k, BOUND);
    lat = cyc - s;
    chk(lat == m_lat, "latency_model", lat, m_lat);
    if (lat_lit >= 0) chk(lat == lat_lit, "latency_literal", lat, lat_lit);
    chk(done_o == m_done, "done_level", done_o, m_done);
    chk(error_o == m_err, "error_level", error_o, m_err);
    chk(!busy_o, "busy_cleared", busy_o, 0);
    chk(rom_addr_o == m_last, "final_addr", rom_addr_o, m_last);
    if (m_err) chk(fail_addr_o == m_fail, "fail_addr", fail_addr_o, m_fail);
    chk(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
    if (gap_lit >= 0) chk(t2 - t1 == gap_lit, "delay_gap", t2 - t1, gap_lit);
    repeat (5) @(negedge clk);
    chk(writes_seen == wr_lit, "write_count", writes_seen, wr_lit);
  endtask

  task automatic load_basic();
    foreach (rom[i]) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'hFF02; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    foreach (nack_plan[i]) nack_plan[i] = 0;
    stall_cfg = 0;
  endtask

  initial begin : main
    int m_lat, k;
    bit m_done, m_err;
    logic [7:0] m_fail, m_last;
    reset_n = 1'b0; start_i = 1'b0; writes_seen = 0;
    load_basic();
    nack_left = nack_plan;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ROM: 14 + (8 units + 4) + 14 + 2 cycles, 12 cycles from FETCH(1) to FETCH(2)
    run_seq(-1, 42, 2, 12);
    chk(done_o && !error_o, "basic_done", {done_o, error_o}, 2);
    run_seq(2, 42, 2, 12);

    stall_cfg = 5;
    run_seq(-1, 52, 2, -1);
    stall_cfg = 0;

    nack_plan[2] = 2;
    run_seq(-1, 64, 4, -1);
    chk(done_o, "nack2_done", done_o, 1);
    nack_plan[2] = 4;
    run_seq(-1, 72, 5, -1);
    chk(error_o && !done_o, "nack4_error", {done_o, error_o}, 1);
    chk(fail_addr_o == 8'd2, "nack4_fail_addr", fail_addr_o, 2);
    nack_plan[2] = 0;
    run_seq(-1, 42, 2, -1);
    chk(done_o && !error_o, "rerun_after_error", {done_o, error_o}, 2);

    foreach (rom[i]) rom[i] = 16'h3A04;
    run_seq(-1, 3584, 256, -1);
    chk(rom_addr_o == 8'd255, "no_marker_last_addr", rom_addr_o, 255);

    // Reset while waiting on the SCCB write of address 1
    load_basic();
    rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    build_model(m_lat, m_done, m_err, m_fail, m_last);
    nack_left = nack_plan; stall_left = 0; writes_seen = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    k = 0;
    while (!(rom_addr_o == 8'd1 && cnt_down >= 3 && cnt_down <= 8) && k < BOUND) begin
      @(negedge clk); k++;
    end
    if (k >= BOUND) chk(0, "timeout_reset_wait", k, BOUND);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_seq(-1, 30, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
